// File: rtl/fp_sum_sequencer.sv
// rtl/fp_sum_sequencer.sv - reduces each burst of single-precision operands to one sum
// through an external stb/ack floating-point adder.
module fp_sum_sequencer #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            input_x,
  input  logic                   input_x_last,
  input  logic                   input_x_stb,
  output logic                   input_x_ack,
  output logic [31:0]            adder_a,
  output logic                   adder_a_stb,
  input  logic                   adder_a_ack,
  output logic [31:0]            adder_b,
  output logic                   adder_b_stb,
  input  logic                   adder_b_ack,
  input  logic [31:0]            adder_z,
  input  logic                   adder_z_stb,
  output logic                   adder_z_ack,
  output logic [31:0]            output_sum,
  output logic [COUNT_WIDTH-1:0] output_count,
  output logic                   output_sum_stb,
  input  logic                   output_sum_ack
);

  typedef enum logic [2:0] {
    get_x,
    put_a,
    put_b,
    get_z,
    put_sum
  } state_t;

  state_t                 state;
  logic [31:0]            acc;
  logic [31:0]            opnd;
  logic                   last_q;
  logic                   first;
  logic [COUNT_WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= get_x;
      acc            <= '0;
      opnd           <= '0;
      last_q         <= 1'b0;
      first          <= 1'b1;
      count          <= '0;
      input_x_ack    <= 1'b0;
      adder_a        <= '0;
      adder_a_stb    <= 1'b0;
      adder_b        <= '0;
      adder_b_stb    <= 1'b0;
      adder_z_ack    <= 1'b0;
      output_sum     <= '0;
      output_count   <= '0;
      output_sum_stb <= 1'b0;
    end else begin
      case (state)
        get_x: begin
          if (!input_x_ack) begin
            input_x_ack <= 1'b1;
          end else if (input_x_stb) begin
            input_x_ack <= 1'b0;
            // Count saturates rather than wrapping on very long bursts.
            if (first) begin
              count <= COUNT_WIDTH'(1);
            end else if (count != '1) begin
              count <= count + COUNT_WIDTH'(1);
            end
            if (first) begin
              acc   <= input_x;
              first <= 1'b0;
              if (input_x_last) state <= put_sum;
            end else begin
              opnd   <= input_x;
              last_q <= input_x_last;
              state  <= put_a;
            end
          end
        end

        put_a: begin
          if (!adder_a_stb) begin
            adder_a     <= acc;
            adder_a_stb <= 1'b1;
          end else if (adder_a_ack) begin
            adder_a_stb <= 1'b0;
            state       <= put_b;
          end
        end

        put_b: begin
          if (!adder_b_stb) begin
            adder_b     <= opnd;
            adder_b_stb <= 1'b1;
          end else if (adder_b_ack) begin
            adder_b_stb <= 1'b0;
            state       <= get_z;
          end
        end

        get_z: begin
          if (!adder_z_ack) begin
            adder_z_ack <= 1'b1;
          end else if (adder_z_stb) begin
            adder_z_ack <= 1'b0;
            acc         <= adder_z;
            state       <= last_q ? put_sum : get_x;
          end
        end

        put_sum: begin
          if (!output_sum_stb) begin
            output_sum     <= acc;
            output_count   <= count;
            output_sum_stb <= 1'b1;
          end else if (output_sum_ack) begin
            output_sum_stb <= 1'b0;
            first          <= 1'b1;
            state          <= get_x;
          end
        end

        default: state <= get_x;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_sum_sequencer.sv
// tb/tb_fp_sum_sequencer.sv - bench for fp_sum_sequencer with a behavioural
// integer-valued float adder peer and an output scoreboard.
module tb_fp_sum_sequencer;

  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   input_x;
  logic          input_x_last;
  logic          input_x_stb;
  logic          input_x_ack;
  logic [31:0]   adder_a;
  logic          adder_a_stb;
  logic          adder_a_ack;
  logic [31:0]   adder_b;
  logic          adder_b_stb;
  logic          adder_b_ack;
  logic [31:0]   adder_z;
  logic          adder_z_stb;
  logic          adder_z_ack;
  logic [31:0]   output_sum;
  logic [CW-1:0] output_count;
  logic          output_sum_stb;
  logic          output_sum_ack;

  fp_sum_sequencer #(.COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .input_x(input_x), .input_x_last(input_x_last),
    .input_x_stb(input_x_stb), .input_x_ack(input_x_ack),
    .adder_a(adder_a), .adder_a_stb(adder_a_stb), .adder_a_ack(adder_a_ack),
    .adder_b(adder_b), .adder_b_stb(adder_b_stb), .adder_b_ack(adder_b_ack),
    .adder_z(adder_z), .adder_z_stb(adder_z_stb), .adder_z_ack(adder_z_ack),
    .output_sum(output_sum), .output_count(output_count),
    .output_sum_stb(output_sum_stb), .output_sum_ack(output_sum_ack)
  );

  initial forever #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] sum;
    int          cnt;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Adder model restricted to integer-valued floats with magnitude below 2^24.
  function automatic int f2i(input logic [31:0] f);
    int p;
    int m;
    if (f[30:23] == 8'd0) return 0;
    p = int'(f[30:23]) - 127;
    m = int'({1'b1, f[22:0]}) >>> (23 - p);
    return f[31] ? -m : m;
  endfunction

  function automatic logic [31:0] i2f(input int v);
    int          mag;
    int          p;
    logic [31:0] r;
    mag = (v < 0) ? -v : v;
    if (mag == 0) return 32'h0;
    p = 0;
    for (int k = 0; k < 24; k++) if (mag >= (1 << k)) p = k;
    r[31]    = (v < 0);
    r[30:23] = 8'(127 + p);
    r[22:0]  = 23'((mag << (23 - p)) & 32'h7FFFFF);
    return r;
  endfunction

  logic        a_stall = 1'b0;
  logic        b_stall = 1'b0;
  logic        sum_hold = 1'b0;
  int          a_xfers = 0;
  int          b_xfers = 0;
  int          a_stb_cycles = 0;

  // Adder peer and output monitor: every decision made at the falling edge,
  // a pending transfer is one where stb and ack are both high until the next rising edge.
  initial begin
    int          phase;
    int          lat;
    logic [31:0] a_val;
    logic [31:0] b_val;
    logic [31:0] cap_a;
    logic [31:0] cap_b;
    logic [31:0] cap_sum;
    logic [CW-1:0] cap_cnt;
    logic        pa;
    logic        pb;
    logic        pz;
    logic        ps;
    exp_t        e;
    phase = 0; lat = 0; pa = 0; pb = 0; pz = 0; ps = 0;
    a_val = 0; b_val = 0; cap_a = 0; cap_b = 0; cap_sum = 0; cap_cnt = 0;
    adder_a_ack = 0; adder_b_ack = 0; adder_z_stb = 0; adder_z = 0;
    output_sum_ack = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        phase = 0; pa = 0; pb = 0; pz = 0; ps = 0;
        adder_a_ack = 0; adder_b_ack = 0; adder_z_stb = 0;
        output_sum_ack = 0;
      end else begin
        if (adder_a_stb) a_stb_cycles++;
        if (pa) begin a_val = cap_a; a_xfers++; phase = 1; end
        if (pb) begin b_val = cap_b; b_xfers++; phase = 2; lat = 3; end
        if (pz) begin adder_z_stb = 0; phase = 0; end
        if (ps) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_sum", cap_sum, 32'hxxxxxxxx);
          end else begin
            e = exp_q.pop_front();
            chk("sum", cap_sum, e.sum);
            chk("count", 32'(cap_cnt), 32'(e.cnt));
          end
        end
        adder_a_ack = (phase == 0) && !a_stall;
        adder_b_ack = (phase == 1) && !b_stall;
        if (phase == 2) begin
          if (lat == 0) begin
            adder_z     = i2f(f2i(a_val) + f2i(b_val));
            adder_z_stb = 1;
            phase       = 3;
          end else begin
            lat--;
          end
        end
        output_sum_ack = !sum_hold;
        pa = adder_a_stb && adder_a_ack;
        pb = adder_b_stb && adder_b_ack;
        pz = adder_z_stb && adder_z_ack;
        ps = output_sum_stb && output_sum_ack;
        cap_a = adder_a; cap_b = adder_b; cap_sum = output_sum; cap_cnt = output_count;
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic l);
    @(negedge clk);
    input_x = d; input_x_last = l; input_x_stb = 1;
    for (int k = 0; k < 400; k++) begin
      if (input_x_ack) begin
        @(negedge clk);
        input_x_stb = 0;
        return;
      end
      @(negedge clk);
    end
    chk("send_timeout", 32'd1, 32'd0);
    input_x_stb = 0;
  endtask

  task automatic drain();
    for (int k = 0; k < 1000; k++) begin
      if (exp_q.size() == 0) return;
      @(negedge clk);
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic push(input logic [31:0] s, input int c);
    exp_t e;
    e.sum = s; e.cnt = c;
    exp_q.push_back(e);
  endtask

  typedef struct {
    int          n;
    logic [31:0] ops [9];
    logic [31:0] exp_sum;
    int          exp_cnt;
  } vec_t;
  vec_t vecs [9];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] ref_a;
    logic [31:0] ref_s;
    logic [CW-1:0] ref_c;
    logic        bad;
    int          pa0;
    int          pb0;
    int          sc0;
    int          got;

    vecs[0] = '{3, '{32'h3F800000, 32'h40000000, 32'h40400000, 0, 0, 0, 0, 0, 0}, 32'h40C00000, 3};
    vecs[1] = '{1, '{32'hBF800000, 0, 0, 0, 0, 0, 0, 0, 0}, 32'hBF800000, 1};
    vecs[2] = '{2, '{32'h3F800000, 32'hBF800000, 0, 0, 0, 0, 0, 0, 0}, 32'h00000000, 2};
    vecs[3] = '{1, '{32'h80000000, 0, 0, 0, 0, 0, 0, 0, 0}, 32'h80000000, 1};
    vecs[4] = '{1, '{32'h7FC12345, 0, 0, 0, 0, 0, 0, 0, 0}, 32'h7FC12345, 1};
    vecs[5] = '{4, '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 0, 0, 0, 0, 0}, 32'h41200000, 4};
    vecs[6] = '{2, '{32'h3F800000, 32'h3F800000, 0, 0, 0, 0, 0, 0, 0}, 32'h40000000, 2};
    vecs[7] = '{2, '{32'h40A00000, 32'hC0400000, 0, 0, 0, 0, 0, 0, 0}, 32'h40000000, 2};
    vecs[8] = '{9, '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                     32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000}, 32'h41100000, 7};

    rst = 1; input_x = 0; input_x_last = 0; input_x_stb = 0;
    repeat (3) @(negedge clk);
    chk("rst_input_x_ack", 32'(input_x_ack), 32'd0);
    chk("rst_stbs", {29'd0, adder_a_stb, adder_b_stb, output_sum_stb}, 32'd0);
    chk("rst_z_ack", 32'(adder_z_ack), 32'd0);
    chk("rst_adder_a", adder_a, 32'd0);
    chk("rst_output_sum", output_sum, 32'd0);
    chk("rst_output_count", 32'(output_count), 32'd0);
    rst = 0;

    for (int i = 0; i < 9; i++) begin
      pa0 = a_xfers; pb0 = b_xfers; sc0 = a_stb_cycles;
      push(vecs[i].exp_sum, vecs[i].exp_cnt);
      for (int j = 0; j < vecs[i].n; j++) send(vecs[i].ops[j], j == vecs[i].n - 1);
      drain();
      chk("a_pairs", 32'(a_xfers - pa0), 32'(vecs[i].n - 1));
      chk("b_pairs", 32'(b_xfers - pb0), 32'(vecs[i].n - 1));
      if (vecs[i].n == 1) chk("bypass_no_a_stb", 32'(a_stb_cycles - sc0), 32'd0);
    end

    // Adder holds off operand a for ten cycles.
    a_stall = 1;
    push(32'h40400000, 2);
    send(32'h3F800000, 0);
    send(32'h40000000, 1);
    got = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      if (adder_a_stb) got = 1; else @(negedge clk);
    end
    chk("stall_a_stb_seen", 32'(got), 32'd1);
    ref_a = adder_a;
    chk("stall_a_value", ref_a, 32'h3F800000);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!adder_a_stb || adder_a !== ref_a || input_x_ack) bad = 1;
    end
    chk("stall_hold", 32'(bad), 32'd0);
    a_stall = 0;
    drain();

    // Downstream holds off the result for eight cycles.
    sum_hold = 1;
    push(32'h40A00000, 2);
    send(32'h40000000, 0);
    send(32'h40400000, 1);
    got = 0;
    for (int k = 0; k < 100 && !got; k++) begin
      if (output_sum_stb) got = 1; else @(negedge clk);
    end
    chk("bp_sum_stb_seen", 32'(got), 32'd1);
    ref_s = output_sum; ref_c = output_count;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (!output_sum_stb || output_sum !== ref_s || output_count !== ref_c || input_x_ack) bad = 1;
    end
    chk("bp_hold", 32'(bad), 32'd0);
    sum_hold = 0;
    drain();
    push(32'h40A00000, 1);
    send(32'h40A00000, 1);
    drain();

    // Reset while the block is presenting operand b.
    b_stall = 1;
    send(32'h3F800000, 0);
    send(32'h40000000, 1);
    got = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      if (adder_b_stb) got = 1; else @(negedge clk);
    end
    chk("rst_mid_put_b_seen", 32'(got), 32'd1);
    rst = 1;
    @(negedge clk);
    chk("rst_mid_handshakes",
        {27'd0, input_x_ack, adder_a_stb, adder_b_stb, adder_z_ack, output_sum_stb}, 32'd0);
    @(negedge clk);
    rst = 0;
    b_stall = 0;
    push(32'h40000000, 2);
    send(32'h3F800000, 0);
    send(32'h3F800000, 1);
    drain();

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
